// File: rtl/taxi_debounce_event_chan.sv
// One channel of the event debouncer.
//
// Synchronises a raw asynchronous input with two flops, shifts the
// synchronised value into an N-deep history on every sample tick, and flips
// the debounced level once all N samples agree with the opposite value.
// A saturating counter measures how many ticks the level has been high and
// raises a long-press indication once it reaches HOLD_TICKS.
//
// Ports:
//   clk      core clock
//   rst      synchronous reset, active-high
//   tick     shared sample strobe from the prescaler
//   in       raw asynchronous input
//   out      debounced level
//   rise     one-cycle pulse on out 0->1
//   fall     one-cycle pulse on out 1->0
//   hold     high while out has been high for >= HOLD_TICKS ticks
//   hold_evt one-cycle pulse when hold asserts
module taxi_debounce_event_chan #(
  parameter int   N          = 4,
  parameter int   HOLD_TICKS = 1000,
  parameter logic INIT       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic hold,
  output logic hold_evt
);

  localparam int CW = $clog2(HOLD_TICKS + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [N-1:0]  hist;
  logic [N-1:0]  hist_shift;
  logic [N-1:0]  hist_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          out_next;
  logic          rise_next;
  logic          fall_next;
  logic          hold_next;
  logic          hold_evt_next;

  // Newest sample enters at bit 0; a single-sample window is just in_sync.
  if (N == 1) begin : g_hist1
    assign hist_shift = sync_p1;
  end else begin : g_histn
    assign hist_shift = {hist[N-2:0], sync_p1};
  end

  always_comb begin
    hist_next     = hist;
    out_next      = out;
    rise_next     = 1'b0;
    fall_next     = 1'b0;
    hold_next     = hold;
    hold_evt_next = 1'b0;
    cnt_next      = cnt;

    if (tick) begin
      hist_next = hist_shift;
      if ((&hist_shift) && !out) begin
        out_next  = 1'b1;
        rise_next = 1'b1;
      end else if (!(|hist_shift) && out) begin
        out_next  = 1'b0;
        fall_next = 1'b1;
      end
    end

    // The rise tick already counts as the first high tick, so key the
    // counter off the level being entered rather than the current one.
    if (fall_next || !out_next) begin
      cnt_next  = '0;
      hold_next = 1'b0;
    end else if (tick && (cnt < CW'(HOLD_TICKS))) begin
      cnt_next = cnt + 1'b1;
      if ((cnt + 1'b1) == CW'(HOLD_TICKS)) begin
        hold_next     = 1'b1;
        hold_evt_next = 1'b1;
      end
    end
  end

  // Stage boundary: synchroniser, history, level, events and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0  <= INIT;
      sync_p1  <= INIT;
      hist     <= {N{INIT}};
      out      <= INIT;
      rise     <= 1'b0;
      fall     <= 1'b0;
      hold     <= 1'b0;
      hold_evt <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_p0  <= in;
      sync_p1  <= sync_p0;
      hist     <= hist_next;
      out      <= out_next;
      rise     <= rise_next;
      fall     <= fall_next;
      hold     <= hold_next;
      hold_evt <= hold_evt_next;
      cnt      <= cnt_next;
    end
  end

endmodule

// File: rtl/taxi_debounce_event.sv
// Multi-channel, rate-configurable debouncer with rise/fall event pulses
// and long-press detection.
//
// A single prescaler produces the sample strobe shared by all channels;
// each channel is an independent taxi_debounce_event_chan.
//
// Ports:
//   clk      core clock
//   rst      synchronous reset, active-high
//   in       raw asynchronous inputs (WIDTH)
//   out      debounced levels (WIDTH)
//   rise     one-cycle pulses on out 0->1 (WIDTH)
//   fall     one-cycle pulses on out 1->0 (WIDTH)
//   hold     long-press levels (WIDTH)
//   hold_evt one-cycle pulses when hold asserts (WIDTH)
//   tick     sample strobe
module taxi_debounce_event #(
  parameter int               WIDTH      = 2,
  parameter int               N          = 4,
  parameter int               RATE       = 125000,
  parameter int               HOLD_TICKS = 1000,
  parameter logic [WIDTH-1:0] INIT       = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] hold,
  output logic [WIDTH-1:0] hold_evt,
  output logic             tick
);

  // RATE=1 would give a zero-width counter; keep one bit that stays at 0.
  localparam int PW = (RATE > 1) ? $clog2(RATE) : 1;

  logic [PW-1:0] pcnt;
  logic          wrap;

  assign wrap = (pcnt == PW'(RATE - 1));
  // Gated so the strobe reads 0 while reset is held, even with RATE=1.
  assign tick = wrap && !rst;

  // Stage boundary: prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (wrap) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    taxi_debounce_event_chan #(
      .N          (N),
      .HOLD_TICKS (HOLD_TICKS),
      .INIT       (INIT[i])
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .in       (in[i]),
      .out      (out[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .hold     (hold[i]),
      .hold_evt (hold_evt[i])
    );
  end

endmodule

// File: doc/taxi_debounce_event.md
Name: taxi_debounce_event

Overview:
- Parametrised successor to the board-level switch debouncer: multi-channel and rate-configurable.
- Adds per-channel rise/fall event pulses and long-press (hold) detection.
- Sits between raw board inputs (buttons, DIP switches, module-present pins) and core logic, in the core clock domain.
- Inputs are asynchronous and are synchronised internally.

Parameters:
- WIDTH, 2, number of independent channels (>=1).
- N, 4, consecutive agreeing samples required to change state (>=1).
- RATE, 125000, clock cycles per sample tick (>=1; 1 = sample every cycle).
- HOLD_TICKS, 1000, sample ticks of continuous high before hold asserts (>=1).
- INIT, '0, WIDTH-bit reset value of out and of the sample history.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- in  in  WIDTH  raw asynchronous inputs.
- out  out  WIDTH  debounced level.
- rise  out  WIDTH  one-cycle pulse when out goes 0->1.
- fall  out  WIDTH  one-cycle pulse when out goes 1->0.
- hold  out  WIDTH  level; high while out has been high >= HOLD_TICKS ticks.
- hold_evt  out  WIDTH  one-cycle pulse when hold asserts.
- tick  out  1  sample strobe (debug/verification).

Behaviour:
- Reset values: out=INIT; history per channel = N copies of INIT bit; rise=fall=hold=hold_evt=0; tick=0; prescaler=0; hold counters=0; synchroniser flops=INIT. Reset never produces events, including when INIT bits are 1.
- Synchroniser: 2-flop per channel; in_sync lags in by 2 cycles.
- Prescaler: counts 0..RATE-1; tick=1 in the cycle the count equals RATE-1, then wraps to 0. RATE=1 gives tick=1 every cycle after reset.
- On a tick cycle, per channel: hist_next = {hist[N-2:0], in_sync}. N=1 means hist = in_sync.
  - If hist_next is all 1 and out=0: out<=1 and rise=1 at the same edge.
  - If hist_next is all 0 and out=1: out<=0 and fall=1 at the same edge.
  - Otherwise out holds.
- rise, fall and hold_evt are high for exactly one cycle. They are cleared on the next edge regardless of tick.
- Latency with RATE=1: a clean input step reaches out 2+N cycles after the input edge. With RATE>1, latency is 2 cycles plus between (N-1)*RATE+1 and N*RATE cycles.
- Glitches: any disagreeing sample within the window restarts agreement. A pulse shorter than N ticks never changes out.
- Hold counter per channel, saturating at HOLD_TICKS:
  - Cleared while out=0, and in the cycle fall fires.
  - Increments on each tick while out=1, including the rise tick (count becomes 1).
  - When the count reaches HOLD_TICKS: hold<=1 and hold_evt=1 on that edge.
  - hold drops together with out on fall.
  - Counter holds at saturation; hold_evt never repeats until after a fall.
- Channels are fully independent. Simultaneous events on different channels all appear in the same cycle.
- Reset mid-operation (including mid-hold or during an event pulse) returns everything to reset values on the next edge. No event is emitted for the reset transition.

Decomposition:
- No shared package. Counter widths are local parameters: $clog2(RATE), $clog2(HOLD_TICKS+1).
- Sub-module taxi_debounce_event_chan: synchroniser, history, out, rise/fall, hold counter for one channel; instantiated WIDTH times.
- One shared prescaler in the top module drives tick to all channels.

Test Plan:
- Reset with INIT=2'b10, in=2'b10, held 20 cycles -> out=2'b10, no rise/fall/hold_evt during or after reset.
- RATE=1, N=4: in[0] 0->1 at cycle 10 -> out[0]=1 and rise[0]=1 (single cycle) at cycle 16; in[0] 1->0 at cycle 30 -> fall[0] at cycle 36.
- RATE=1, N=4: in[0] high for 3 cycles, then low -> no change on out[0], no pulses; alternating 0/1 every cycle for 50 cycles -> out stable.
- RATE=5, N=4, HOLD_TICKS=3: hold in[1] high -> rise, then hold_evt[1] one cycle exactly 2 ticks (10 cycles) after rise, hold[1]=1 until release; on release, hold and out fall together; a second press repeats hold_evt.
- Both channels step simultaneously -> rise=2'b11 in the same cycle; then release ch0 only -> fall=2'b01, ch1 unaffected.
- Assert rst while hold[0]=1 and a fall pulse is pending -> next cycle all outputs at reset values; after rst deasserts, in held high -> a fresh rise occurs with full 2+N latency.
